// File: rtl/md_pad_pkg.sv
// Shared constants and output mux for the Sega 6-button pad model.
package md_pad_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_X     = 8;
  localparam int unsigned BTN_Y     = 9;
  localparam int unsigned BTN_Z     = 10;
  localparam int unsigned BTN_MODE  = 11;

  localparam int unsigned PIN_W = 7;
  localparam int unsigned BTN_W = 12;
  localparam int unsigned PH_W  = 3;

  // Even phases are TH high, odd phases TH low.
  localparam logic [PH_W-1:0] PH_HI0 = 3'd0;
  localparam logic [PH_W-1:0] PH_LO0 = 3'd1;
  localparam logic [PH_W-1:0] PH_HI1 = 3'd2;
  localparam logic [PH_W-1:0] PH_LO1 = 3'd3;
  localparam logic [PH_W-1:0] PH_HI2 = 3'd4;
  localparam logic [PH_W-1:0] PH_LO2 = 3'd5;
  localparam logic [PH_W-1:0] PH_HI3 = 3'd6;
  localparam logic [PH_W-1:0] PH_LO3 = 3'd7;

  // 1.5 ms of MCLK at the NTSC master clock, rounded up.
  localparam int unsigned MCLK_HZ         = 53_693_175;
  localparam int unsigned TIMEOUT_DEFAULT = (MCLK_HZ * 3 + 1999) / 2000;

  // Active-low pin pattern for a given phase; bit 6 mirrors TH.
  function automatic logic [PIN_W-1:0] pad_mux(input logic [PH_W-1:0] phase,
                                               input logic             th,
                                               input logic [BTN_W-1:0] btn);
    logic [BTN_W-1:0] n;
    n = ~btn;
    case (phase)
      PH_LO0, PH_LO1: pad_mux = {th, n[BTN_START], n[BTN_A], 2'b00, n[BTN_DOWN], n[BTN_UP]};
      PH_LO2:         pad_mux = {th, n[BTN_START], n[BTN_A], 4'b0000};
      PH_HI3:         pad_mux = {th, n[BTN_C], n[BTN_B], n[BTN_MODE], n[BTN_X], n[BTN_Y], n[BTN_Z]};
      PH_LO3:         pad_mux = {th, n[BTN_START], n[BTN_A], 4'b1111};
      default:        pad_mux = {th, n[BTN_C], n[BTN_B], n[BTN_RIGHT], n[BTN_LEFT],
                                 n[BTN_DOWN], n[BTN_UP]};
    endcase
  endfunction

endpackage

// File: rtl/md_pad6.sv
// One Sega control pad on a controller port: TH-toggle phase counter with
// inactivity timeout, returning registered active-low pin levels.
module md_pad6
  import md_pad_pkg::*;
#(
  parameter int unsigned SIX_BUTTON = 1,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned TW         = 17
) (
  input  logic             MCLK,
  input  logic             ext_reset,
  input  logic [6:0]       port_o,
  input  logic [6:0]       port_d,
  input  logic [11:0]      btn,
  output logic [6:0]       port_i
);

  logic            th;
  logic            th_edge;
  logic            th_q;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PIN_W-1:0] pins_q, pins_d;
  logic            unused_pins;

  // Pins 5:0 are always driven by the pad, so their port levels are ignored.
  assign unused_pins = ^{port_o[5:0], port_d[5:0]};

  // An undriven TH pin is pulled high.
  assign th      = port_d[6] ? 1'b1 : port_o[6];
  assign th_edge = (th != th_q);

  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    if (SIX_BUTTON != 0) begin
      if (th_edge) begin
        phase_d = phase_q + PH_W'(1);
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT)) begin
        phase_d = {2'b00, ~th};
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      phase_d = {2'b00, ~th};
      timer_d = '0;
    end
    pins_d = pad_mux(phase_d, th, btn);
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      th_q    <= 1'b1;
      phase_q <= PH_HI0;
      timer_q <= '0;
      pins_q  <= 7'h7f;
    end else begin
      th_q    <= th;
      phase_q <= phase_d;
      timer_q <= timer_d;
      pins_q  <= pins_d;
    end
  end

  assign port_i = pins_q;

endmodule

// File: tb/tb_md_pad6.sv
// Randomised scoreboard bench for md_pad6 (6-button and 3-button instances).
module tb_md_pad6;
  import md_pad_pkg::*;

  localparam int unsigned TO = 100;

  logic        MCLK = 1'b0;
  logic        ext_reset = 1'b1;
  logic [6:0]  port_o = 7'h00;
  logic [6:0]  port_d = 7'h7f;
  logic [11:0] btn = 12'h000;
  logic [6:0]  pi6, pi3;

  always #5 MCLK = ~MCLK;

  md_pad6 #(.SIX_BUTTON(1), .TIMEOUT(TO), .TW(17)) dut6 (
    .MCLK(MCLK), .ext_reset(ext_reset), .port_o(port_o), .port_d(port_d),
    .btn(btn), .port_i(pi6));

  md_pad6 #(.SIX_BUTTON(0), .TIMEOUT(TO), .TW(17)) dut3 (
    .MCLK(MCLK), .ext_reset(ext_reset), .port_o(port_o), .port_d(port_d),
    .btn(btn), .port_i(pi3));

  int checks = 0;
  int errors = 0;
  logic [6:0] q6[$];
  logic [6:0] q3[$];

  // Reference state: phase as a plain integer, timeout from the cycle stamp of the last TH edge.
  int cyc = 0;
  int last_edge = 0;
  int ph = 0;
  bit th_prev = 1'b1;
  logic [11:0] cur_btn = 12'h000;

  function automatic logic [6:0] ref_out(input int p, input bit th, input logic [11:0] b);
    bit u, d, l, r, a, bb, c, s, x, y, z, m;
    u = !b[0]; d = !b[1]; l = !b[2]; r = !b[3]; a = !b[4]; bb = !b[5];
    c = !b[6]; s = !b[7]; x = !b[8]; y = !b[9]; z = !b[10]; m = !b[11];
    if (p == 6)                return {th, c, bb, m, x, y, z};
    else if (p == 7)           return {th, s, a, 4'b1111};
    else if (p == 5)           return {th, s, a, 4'b0000};
    else if (p == 1 || p == 3) return {th, s, a, 1'b0, 1'b0, d, u};
    else                       return {th, c, bb, r, l, d, u};
  endfunction

  task automatic step(input bit rst, input logic [6:0] po, input logic [6:0] pd,
                      input logic [11:0] b);
    bit th;
    @(negedge MCLK);
    ext_reset = rst;
    port_o = po;
    port_d = pd;
    btn = b;
    th = pd[6] ? 1'b1 : po[6];
    if (rst) begin
      th_prev = 1'b1;
      ph = 0;
      last_edge = cyc;
      q6.push_back(7'h7f);
      q3.push_back(7'h7f);
    end else begin
      if (th != th_prev) begin
        ph = (ph + 1) % 8;
        last_edge = cyc;
      end else if (cyc - last_edge >= int'(TO) + 1) begin
        ph = th ? 0 : 1;
      end
      th_prev = th;
      q6.push_back(ref_out(ph, th, b));
      q3.push_back(ref_out(th ? 0 : 1, th, b));
    end
    cyc++;
  endtask

  task automatic hold(input bit lvl, input int n);
    logic [6:0] po;
    for (int i = 0; i < n; i++) begin
      po = 7'($urandom);
      po[6] = lvl;
      step(1'b0, po, {1'b0, 6'($urandom)}, cur_btn);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 1);
      hold(1'b1, 1);
    end
  endtask

  // Check pins immediately after reset is raised, before any clock edge.
  task automatic async_reset_check();
    step(1'b1, port_o, port_d, cur_btn);
    #1;
    checks++;
    if (pi6 !== 7'h7f) begin
      errors++;
      $display("FAIL async_reset pad6 got %h want 7f", pi6);
    end
    checks++;
    if (pi3 !== 7'h7f) begin
      errors++;
      $display("FAIL async_reset pad3 got %h want 7f", pi3);
    end
  endtask

  // Monitor: outputs present every cycle, one expectation per clocked step.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge MCLK);
      #1;
      if (q6.size() > 0) begin
        e = q6.pop_front();
        checks++;
        if (pi6 !== e) begin
          errors++;
          $display("FAIL pad6 t=%0t got %h want %h", $time, pi6, e);
        end
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        checks++;
        if (pi3 !== e) begin
          errors++;
          $display("FAIL pad3 t=%0t got %h want %h", $time, pi3, e);
        end
      end
    end
  end

  initial begin
    int len;
    bit lvl;
    step(1'b1, 7'h00, 7'h7f, 12'h000);
    step(1'b1, 7'h00, 7'h7f, 12'h000);
    // TH floating high, then driven low.
    for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 7'h7f, 12'h000);
    step(1'b0, 7'h00, 7'h00, 12'h000);
    // A+Start in TH low, released with TH high.
    cur_btn = 12'h090;
    hold(1'b0, 2);
    cur_btn = 12'h000;
    hold(1'b1, 2);
    // Let the timeout settle the phase, then walk to phase 6/7 with X held and without.
    hold(1'b1, 110);
    cur_btn = 12'h100;
    pulses(3);
    hold(1'b0, 1);
    hold(1'b1, 110);
    cur_btn = 12'h000;
    pulses(2);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 110);
    // Timeout boundary: hold high around TIMEOUT after the fourth rise, then drop TH.
    for (int h = 98; h <= 103; h++) begin
      pulses(4);
      cur_btn = 12'hfff;
      hold(1'b1, h);
      hold(1'b0, 2);
      cur_btn = 12'h000;
      hold(1'b1, 110);
    end
    // Async reset in phase 6, then three-button instance sees Z ignored.
    cur_btn = 12'h100;
    pulses(3);
    async_reset_check();
    step(1'b0, 7'h40, 7'h00, cur_btn);
    hold(1'b0, 1);
    cur_btn = 12'h400;
    pulses(3);
    hold(1'b1, 2);
    // Random traffic with occasional long idles and resets.
    lvl = 1'b1;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) == 0) cur_btn = 12'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        step(1'b1, 7'($urandom), 7'($urandom), cur_btn);
        lvl = 1'b1;
      end
      if ($urandom_range(0, 4) != 0) lvl = !lvl;
      len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4))
                                       : int'($urandom_range(95, 106));
      if (lvl && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < len; i++)
          step(1'b0, 7'($urandom), {1'b1, 6'($urandom)}, cur_btn);
      end else begin
        hold(lvl, len);
      end
    end
    repeat (3) @(posedge MCLK);
    #2;
    checks++;
    if (q6.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d/%0d want 0/0", q6.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
